alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a byte-serial ALU: CTL beat, data beats, wait for result.
// Optional WAIT-state timeout is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        tb_clk,
    input  logic        tb_rst_n,
    input  logic [1:0]  req_val,
    input  logic [15:0] req_op,
    input  logic [5:0]  req_len,
    input  logic [63:0] req_data,
    output logic [1:0]  req_rdy,
    output logic [1:0]  rsp_val,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy,
    output logic        alu_ctl,
    output logic [7:0]  alu_dat,
    input  logic        alu_ready,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {IDLE, CTL, DATA, WAIT} state_t;

    state_t      state;
    logic        last;
    logic        gnt_q;
    logic [2:0]  rem;
    logic [31:0] data_q;

    logic        gnt;
    logic [2:0]  len_raw;
    logic [2:0]  len_sel;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("alu_arbiter: TIMEOUT_CYC must be 1..65535");
    end

    // Contended: the requester after the last completed grant wins.
    always_comb begin
        gnt = req_val[1];
        if (req_val == 2'b11) gnt = ~last;
    end

    assign len_raw = gnt ? req_len[5:3] : req_len[2:0];
    assign len_sel = (len_raw > 3'd4) ? 3'd4 : len_raw;

    assign req_rdy = (state == IDLE && tb_rst_n && (|req_val)) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign busy    = (state != IDLE);

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            gnt_q      <= 1'b0;
            rem        <= 3'd0;
            data_q     <= 32'd0;
            rsp_val    <= 2'b00;
            rsp_result <= 32'd0;
            alu_ctl    <= 1'b0;
            alu_dat    <= 8'd0;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
            tmo_cnt    <= 16'd0;
`endif
        end else begin
            rsp_val <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req_val) begin
                        gnt_q   <= gnt;
                        state   <= CTL;
                        alu_ctl <= 1'b1;
                        alu_dat <= gnt ? req_op[15:8] : req_op[7:0];
                        data_q  <= gnt ? req_data[63:32] : req_data[31:0];
                        rem     <= len_sel;
                    end
                end
                CTL, DATA: begin
                    // rem counts bytes still to present after the current beat.
                    alu_ctl <= 1'b0;
                    if (rem == 3'd0) begin
                        state   <= WAIT;
                        alu_dat <= 8'd0;
`ifdef ALU_ARB_TIMEOUT_EN
                        tmo_cnt <= 16'd0;
`endif
                    end else begin
                        state   <= DATA;
                        alu_dat <= data_q[7:0];
                        data_q  <= data_q >> 8;
                        rem     <= rem - 3'd1;
                    end
                end
                WAIT: begin
                    if (alu_ready) begin
                        rsp_result <= alu_result;
                        rsp_val    <= gnt_q ? 2'b10 : 2'b01;
                        last       <= gnt_q;
                        state      <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
                        rsp_err    <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_result <= 32'd0;
                        rsp_val    <= gnt_q ? 2'b10 : 2'b01;
                        rsp_err    <= 1'b1;
                        last       <= gnt_q;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt    <= tmo_cnt + 16'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant/beat sequencing, round-robin, length clamp, reset, optional timeout.
module tb_alu_arbiter;

    logic        tb_clk = 1'b0;
    logic        tb_rst_n = 1'b0;
    logic [1:0]  req_val = '0;
    logic [15:0] req_op = '0;
    logic [5:0]  req_len = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_rdy, rsp_val;
    logic [31:0] rsp_result;
    logic        rsp_err, busy, alu_ctl;
    logic [7:0]  alu_dat;
    logic        alu_ready = 1'b0;
    logic [31:0] alu_result = '0;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.TIMEOUT_CYC(8)) dut (
        .tb_clk(tb_clk), .tb_rst_n(tb_rst_n),
        .req_val(req_val), .req_op(req_op), .req_len(req_len), .req_data(req_data),
        .req_rdy(req_rdy), .rsp_val(rsp_val), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy), .alu_ctl(alu_ctl), .alu_dat(alu_dat),
        .alu_ready(alu_ready), .alu_result(alu_result)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic nxt(); @(posedge tb_clk); #1; endtask
    task automatic smp(); @(negedge tb_clk); endtask

    task automatic test_reset();
        tb_rst_n = 1'b0;
        req_val  = 2'b01;
        repeat (2) nxt();
        smp();
        checks++; if (req_rdy !== 2'b00) begin errors++; $display("FAIL rst_rdy got %b want 00", req_rdy); end
        checks++; if (rsp_val !== 2'b00) begin errors++; $display("FAIL rst_rsp_val got %b want 00", rsp_val); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", rsp_result); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (alu_ctl !== 1'b0 || alu_dat !== 8'h00) begin errors++; $display("FAIL rst_alu got %b/%h want 0/00", alu_ctl, alu_dat); end
        nxt();
        req_val  = 2'b00;
        tb_rst_n = 1'b1;
    endtask

    task automatic test_single();
        nxt();
        req_val = 2'b01; req_op = {8'h00, 8'h21}; req_len = {3'd0, 3'd2}; req_data = {32'h0, 32'h0000_BEEF};
        smp();
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL single_rdy got %b want 01", req_rdy); end
        nxt(); req_val = 2'b00; smp();
        checks++; if (alu_ctl !== 1'b1 || alu_dat !== 8'h21) begin errors++; $display("FAIL single_ctl got %b/%h want 1/21", alu_ctl, alu_dat); end
        checks++; if (busy !== 1'b1 || req_rdy !== 2'b00) begin errors++; $display("FAIL single_busy got %b/%b want 1/00", busy, req_rdy); end
        nxt(); smp();
        checks++; if (alu_ctl !== 1'b0 || alu_dat !== 8'hEF) begin errors++; $display("FAIL single_b0 got %b/%h want 0/EF", alu_ctl, alu_dat); end
        nxt(); smp();
        checks++; if (alu_dat !== 8'hBE) begin errors++; $display("FAIL single_b1 got %h want BE", alu_dat); end
        nxt(); alu_ready = 1'b1; alu_result = 32'h1234_5678; smp();
        checks++; if (alu_dat !== 8'h00 || rsp_val !== 2'b00) begin errors++; $display("FAIL single_wait got %h/%b want 00/00", alu_dat, rsp_val); end
        nxt(); alu_ready = 1'b0; alu_result = '0; smp();
        checks++; if (rsp_val !== 2'b01 || rsp_result !== 32'h1234_5678 || rsp_err !== 1'b0)
            begin errors++; $display("FAIL single_rsp got %b/%h/%b want 01/12345678/0", rsp_val, rsp_result, rsp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
        nxt(); smp();
        checks++; if (rsp_val !== 2'b00 || rsp_result !== 32'h1234_5678) begin errors++; $display("FAIL single_hold got %b/%h want 00/12345678", rsp_val, rsp_result); end
    endtask

    task automatic test_arb();
        logic [1:0]  exp_g;
        logic [1:0]  nxt_g;
        logic [7:0]  exp_op;
        nxt(); tb_rst_n = 1'b0;
        nxt(); tb_rst_n = 1'b1;
        req_val = 2'b11; req_op = {8'h31, 8'h30}; req_len = '0; req_data = '0;
        smp();
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL arb_first got %b want 01", req_rdy); end
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 1) ? 2'b10 : 2'b01;
            nxt_g  = (k == 3) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
            exp_op = (k % 2 == 1) ? 8'h31 : 8'h30;
            nxt(); smp();
            checks++; if (alu_ctl !== 1'b1 || alu_dat !== exp_op) begin errors++; $display("FAIL arb_ctl%0d got %b/%h want 1/%h", k, alu_ctl, alu_dat, exp_op); end
            nxt(); alu_ready = 1'b1; alu_result = 32'hA000_0000 + k; smp();
            nxt(); alu_ready = 1'b0; if (k == 3) req_val = 2'b00; smp();
            checks++; if (rsp_val !== exp_g || rsp_result !== 32'hA000_0000 + k)
                begin errors++; $display("FAIL arb_rsp%0d got %b/%h want %b/%h", k, rsp_val, rsp_result, exp_g, 32'hA000_0000 + k); end
            checks++; if (req_rdy !== nxt_g) begin errors++; $display("FAIL arb_regrant%0d got %b want %b", k, req_rdy, nxt_g); end
        end
    endtask

    task automatic test_len_clamp();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        nxt();
        req_val = 2'b10; req_op = {8'h44, 8'h00}; req_len = {3'd7, 3'd0}; req_data = {32'hDDCC_BBAA, 32'h0};
        smp();
        checks++; if (req_rdy !== 2'b10) begin errors++; $display("FAIL clamp_rdy got %b want 10", req_rdy); end
        nxt(); req_val = 2'b00; smp();
        checks++; if (alu_ctl !== 1'b1 || alu_dat !== 8'h44) begin errors++; $display("FAIL clamp_ctl got %b/%h want 1/44", alu_ctl, alu_dat); end
        for (int i = 0; i < 4; i++) begin
            nxt(); smp();
            checks++; if (alu_dat !== exp_b[i]) begin errors++; $display("FAIL clamp_b%0d got %h want %h", i, alu_dat, exp_b[i]); end
        end
        nxt(); smp();
        checks++; if (alu_dat !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL clamp_wait got %h/%b want 00/1", alu_dat, busy); end
        nxt(); alu_ready = 1'b1; alu_result = 32'h5555_AAAA; smp();
        nxt(); alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b10 || rsp_result !== 32'h5555_AAAA) begin errors++; $display("FAIL clamp_rsp got %b/%h want 10/5555AAAA", rsp_val, rsp_result); end
    endtask

    task automatic test_len0_stray();
        nxt();
        req_val = 2'b01; req_op = {8'h00, 8'h05}; req_len = '0; req_data = {32'h0, 32'hFFFF_FFFF};
        smp();
        nxt(); req_val = 2'b00; smp();
        checks++; if (alu_ctl !== 1'b1 || alu_dat !== 8'h05) begin errors++; $display("FAIL len0_ctl got %b/%h want 1/05", alu_ctl, alu_dat); end
        for (int i = 0; i < 2; i++) begin
            nxt(); smp();
            checks++; if (alu_ctl !== 1'b0 || alu_dat !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL len0_wait%0d got %b/%h/%b want 0/00/1", i, alu_ctl, alu_dat, busy); end
        end
        nxt(); alu_ready = 1'b1; alu_result = 32'h0000_0ABC; smp();
        nxt(); alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b01 || rsp_result !== 32'h0000_0ABC) begin errors++; $display("FAIL len0_rsp got %b/%h want 01/00000ABC", rsp_val, rsp_result); end
        nxt(); alu_ready = 1'b1; alu_result = 32'hFFFF_FFFF; smp();
        nxt(); alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b00 || rsp_result !== 32'h0000_0ABC || busy !== 1'b0)
            begin errors++; $display("FAIL stray_idle got %b/%h/%b want 00/00000ABC/0", rsp_val, rsp_result, busy); end
    endtask

    task automatic test_reset_mid();
        nxt();
        req_val = 2'b01; req_op = {8'h77, 8'h66}; req_len = {3'd0, 3'd3}; req_data = {32'h0, 32'h0033_2211};
        smp();
        nxt(); req_val = 2'b00; smp();
        nxt(); smp();
        checks++; if (alu_dat !== 8'h11) begin errors++; $display("FAIL rmid_b0 got %h want 11", alu_dat); end
        nxt(); smp();
        checks++; if (alu_dat !== 8'h22) begin errors++; $display("FAIL rmid_b1 got %h want 22", alu_dat); end
        #1 tb_rst_n = 1'b0;
        #1;
        checks++; if (alu_ctl !== 1'b0 || alu_dat !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rmid_async got %b/%h/%b want 0/00/0", alu_ctl, alu_dat, busy); end
        nxt(); alu_ready = 1'b1; alu_result = 32'hDEAD_DEAD;
        nxt(); tb_rst_n = 1'b1; alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b00 || rsp_result !== 32'd0) begin errors++; $display("FAIL rmid_norsp got %b/%h want 00/0", rsp_val, rsp_result); end
        nxt(); req_val = 2'b11; req_len = '0; smp();
        checks++; if (req_rdy !== 2'b01) begin errors++; $display("FAIL rmid_regrant got %b want 01", req_rdy); end
        nxt(); req_val = 2'b00; smp();
        checks++; if (alu_ctl !== 1'b1 || alu_dat !== 8'h66) begin errors++; $display("FAIL rmid_ctl got %b/%h want 1/66", alu_ctl, alu_dat); end
        nxt(); smp();
        nxt(); alu_ready = 1'b1; alu_result = 32'hCAFE_0001; smp();
        nxt(); alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b01 || rsp_result !== 32'hCAFE_0001) begin errors++; $display("FAIL rmid_rsp got %b/%h want 01/CAFE0001", rsp_val, rsp_result); end
    endtask

`ifdef ALU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        nxt();
        req_val = 2'b01; req_op = {8'h00, 8'h07}; req_len = '0;
        smp();
        nxt(); req_val = 2'b00; smp();
        for (int i = 1; i <= 8; i++) begin
            nxt(); smp();
            checks++; if (rsp_val !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL tmo_w%0d got %b/%b want 00/1", i, rsp_val, busy); end
        end
        nxt(); smp();
        checks++; if (rsp_val !== 2'b01 || rsp_err !== 1'b1 || rsp_result !== 32'd0)
            begin errors++; $display("FAIL tmo_rsp got %b/%b/%h want 01/1/0", rsp_val, rsp_err, rsp_result); end
        nxt(); alu_ready = 1'b1; alu_result = 32'h9999_9999; smp();
        nxt(); alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b00 || rsp_result !== 32'd0) begin errors++; $display("FAIL tmo_stray got %b/%h want 00/0", rsp_val, rsp_result); end
        // ready coincides with the final WAIT cycle: normal completion wins
        nxt(); req_val = 2'b01; smp();
        nxt(); req_val = 2'b00; smp();
        for (int i = 1; i <= 7; i++) begin nxt(); smp(); end
        nxt(); alu_ready = 1'b1; alu_result = 32'h0BAD_F00D; smp();
        checks++; if (rsp_val !== 2'b00) begin errors++; $display("FAIL tmo_tie_early got %b want 00", rsp_val); end
        nxt(); alu_ready = 1'b0; smp();
        checks++; if (rsp_val !== 2'b01 || rsp_err !== 1'b0 || rsp_result !== 32'h0BAD_F00D)
            begin errors++; $display("FAIL tmo_tie got %b/%b/%h want 01/0/0BADF00D", rsp_val, rsp_err, rsp_result); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_arb();
        test_len_clamp();
        test_len0_stray();
        test_reset_mid();
`ifdef ALU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
